// File: rtl/gpi_debounce.sv
// gpi_debounce: synchronizes and debounces a raw push-button pad into a clean pressed-high level.
// Ports: clock, reset (synchronous, active-high), btn_i raw asynchronous pad,
//        level_o debounced state (1 = pressed), press_o/release_o one-cycle strobes on accepted edges.
// Macro GPI_DEBOUNCE_STROBE_EN compiles in the strobe registers; without it both strobes are tied to 0.
module gpi_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;
  state_t state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic level_q, s, done;
  assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
  // a wait state completes only if its final count still sees the new value
  assign done = cnt_q == LAST;
  always_ff @(posedge clock)
    sync_q <= reset ? {SYNC_STAGES{ACTIVE_LOW}} : {sync_q[SYNC_STAGES-2:0], btn_i};
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      case (state_q)
        RELEASED: begin
          state_q <= s ? WAIT_PRESS : RELEASED;
          cnt_q   <= s ? CW'(1) : '0;
        end
        WAIT_PRESS: begin
          state_q <= !s ? RELEASED : done ? PRESSED : WAIT_PRESS;
          cnt_q   <= (!s || done) ? '0 : cnt_q + CW'(1);
          level_q <= s && done;
        end
        PRESSED: begin
          state_q <= !s ? WAIT_RELEASE : PRESSED;
          cnt_q   <= !s ? CW'(1) : '0;
        end
        default: begin
          state_q <= s ? PRESSED : done ? RELEASED : WAIT_RELEASE;
          cnt_q   <= (s || done) ? '0 : cnt_q + CW'(1);
          level_q <= s || !done;
        end
      endcase
    end
  end
  assign level_o = level_q;
`ifdef GPI_DEBOUNCE_STROBE_EN
  logic press_q, release_q;
  always_ff @(posedge clock) begin
    press_q   <= !reset && state_q == WAIT_PRESS && s && done;
    release_q <= !reset && state_q == WAIT_RELEASE && !s && done;
  end
  assign press_o   = press_q;
  assign release_o = release_q;
`else
  assign press_o   = 1'b0;
  assign release_o = 1'b0;
`endif
endmodule
